// File: rtl/gate_pool_arbiter.sv
// gate_pool_arbiter
// Owns the gate-pool lock bitmap. Hands the lowest-index free gate to
// requesters in round-robin order, at most one grant every two cycles, and
// accepts gate releases in any cycle. All outputs are registered.

module gate_pool_arbiter #(
   parameter int POOL_WIDTH = 32,
   parameter int N_REQ      = 4,
   parameter int IDX_W      = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      i_req,
   input  logic                  i_rel_valid,
   input  logic [IDX_W-1:0]      i_rel_idx,
   output logic                  o_grant_valid,
   output logic [N_REQ-1:0]      o_grant_req,
   output logic [IDX_W-1:0]      o_grant_idx,
   output logic [POOL_WIDTH-1:0] o_pool_lock,
   output logic                  o_pool_full,
   output logic [IDX_W:0]        o_free_count,
   output logic                  o_rel_err
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // COOL is the one-cycle gap after a grant that lets the winner drop i_req.
   typedef enum logic {
      ARB  = 1'b0,
      COOL = 1'b1
   } state_t;

   state_t               state;
   logic [PTR_W-1:0]     ptr;

   logic                 req_any;
   logic                 grant_fire;
   logic [PTR_W-1:0]     winner;
   logic [IDX_W-1:0]     gate_idx;
   logic                 rel_hit;
   logic                 rel_miss;
   logic [POOL_WIDTH-1:0] lock_next;
   logic [IDX_W:0]       free_next;
   int                   cand;

   // Round-robin pick: first requester at or after ptr, wrapping modulo N_REQ.
   // NOTE: every combinational output gets a default before the loop so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      winner  = '0;
      cand    = 0;
      req_any = |i_req;
      // Walk from the far end back toward ptr so the nearest candidate wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (i_req[cand]) begin
            winner = PTR_W'(cand);
         end
      end
   end

   // Lowest-index free gate in the registered bitmap (pre-release view).
   always_comb begin
      gate_idx = '0;
      for (int i = POOL_WIDTH - 1; i >= 0; i--) begin
         if (!o_pool_lock[i]) begin
            gate_idx = IDX_W'(i);
         end
      end
   end

   // Next bitmap: apply this cycle's grant and release, then recount.
   // A granted gate is free and a valid release hits a locked gate, so the
   // two updates can never target the same bit.
   always_comb begin
      grant_fire = (state == ARB) && req_any && !o_pool_full;
      rel_hit    = i_rel_valid &&  o_pool_lock[i_rel_idx];
      rel_miss   = i_rel_valid && !o_pool_lock[i_rel_idx];
      lock_next  = o_pool_lock;
      if (grant_fire) begin
         lock_next[gate_idx] = 1'b1;
      end
      if (rel_hit) begin
         lock_next[i_rel_idx] = 1'b0;
      end
      free_next = '0;
      for (int i = 0; i < POOL_WIDTH; i++) begin
         free_next = free_next + (IDX_W+1)'(!lock_next[i]);
      end
   end

   // FSM, round-robin pointer and all registered outputs.
   // NOTE: state is updated with non-blocking assignments so every register
   // sees the pre-edge value of every other, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB;
         ptr           <= '0;
         o_grant_valid <= 1'b0;
         o_grant_req   <= '0;
         o_grant_idx   <= '0;
         o_pool_lock   <= '0;
         o_pool_full   <= 1'b0;
         o_free_count  <= (IDX_W+1)'(POOL_WIDTH);
         o_rel_err     <= 1'b0;
      end else begin
         o_grant_valid <= 1'b0;
         o_grant_req   <= '0;
         o_grant_idx   <= '0;
         o_rel_err     <= rel_miss;
         o_pool_lock   <= lock_next;
         o_pool_full   <= &lock_next;
         o_free_count  <= free_next;
         case (state)
            ARB: begin
               if (grant_fire) begin
                  o_grant_valid <= 1'b1;
                  o_grant_req   <= N_REQ'(1) << winner;
                  o_grant_idx   <= gate_idx;
                  ptr           <= (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                  state         <= COOL;
               end
            end
            COOL: begin
               state <= ARB;
            end
            default: begin
               state <= ARB;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_pool_arbiter.sv
// tb_gate_pool_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a cycle-level reference model of the pool and arbitration rules.

module tb_gate_pool_arbiter;

   localparam int PW = 32;
   localparam int NR = 4;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic          rel_valid;
   logic [IW-1:0] rel_idx;
   logic          o_grant_valid;
   logic [NR-1:0] o_grant_req;
   logic [IW-1:0] o_grant_idx;
   logic [PW-1:0] o_pool_lock;
   logic          o_pool_full;
   logic [IW:0]   o_free_count;
   logic          o_rel_err;

   int checks = 0;
   int errors = 0;

   // Reference model state and expected outputs.
   logic [PW-1:0] m_lock;
   int            m_ptr;
   bit            m_cool;
   logic          e_gv;
   logic [NR-1:0] e_greq;
   logic [IW-1:0] e_gidx;
   logic          e_err;
   logic          e_full;
   logic [IW:0]   e_free;

   gate_pool_arbiter #(.POOL_WIDTH(PW), .N_REQ(NR), .IDX_W(IW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req         (req),
      .i_rel_valid   (rel_valid),
      .i_rel_idx     (rel_idx),
      .o_grant_valid (o_grant_valid),
      .o_grant_req   (o_grant_req),
      .o_grant_idx   (o_grant_idx),
      .o_pool_lock   (o_pool_lock),
      .o_pool_full   (o_pool_full),
      .o_free_count  (o_free_count),
      .o_rel_err     (o_rel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_edge();
      logic [PW-1:0] nl;
      int w;
      int g;
      int cnt;
      if (rst) begin
         m_lock = '0; m_ptr = 0; m_cool = 0;
         e_gv = 0; e_greq = '0; e_gidx = '0; e_err = 0;
         e_full = 0; e_free = (IW+1)'(PW);
         return;
      end
      e_gv = 0; e_greq = '0; e_gidx = '0; e_err = 0;
      nl = m_lock;
      if (!m_cool && req != '0 && m_lock != '1) begin
         w = -1;
         for (int k = 0; k < NR; k++)
            if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
         g = -1;
         for (int i = 0; i < PW; i++)
            if (g < 0 && !m_lock[i]) g = i;
         e_gv   = 1;
         e_greq = NR'(1 << w);
         e_gidx = IW'(g);
         nl[g]  = 1'b1;
         m_ptr  = (w + 1) % NR;
         m_cool = 1;
      end else begin
         m_cool = 0;
      end
      if (rel_valid) begin
         if (m_lock[rel_idx]) nl[rel_idx] = 1'b0;
         else                 e_err = 1;
      end
      m_lock = nl;
      cnt = 0;
      for (int i = 0; i < PW; i++) if (!nl[i]) cnt++;
      e_free = (IW+1)'(cnt);
      e_full = (nl == '1);
   endtask

   // One clock: model at the edge, compare all outputs mid-cycle.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("grant_valid", 64'(o_grant_valid), 64'(e_gv));
      check("grant_req",   64'(o_grant_req),   64'(e_greq));
      check("grant_idx",   64'(o_grant_idx),   64'(e_gidx));
      check("pool_lock",   64'(o_pool_lock),   64'(m_lock));
      check("pool_full",   64'(o_pool_full),   64'(e_full));
      check("free_count",  64'(o_free_count),  64'(e_free));
      check("rel_err",     64'(o_rel_err),     64'(e_err));
   endtask

   task automatic do_reset();
      rst = 1; req = '0; rel_valid = 0; rel_idx = '0;
      step();
      step();
      rst = 0;
   endtask

   initial begin
      logic [NR-1:0] pend;

      // Reset values.
      @(negedge clk);
      do_reset();
      check("rst_lock",  64'(o_pool_lock),  64'h0);
      check("rst_free",  64'(o_free_count), 64'd32);
      check("rst_full",  64'(o_pool_full),  64'h0);
      check("rst_gv",    64'(o_grant_valid), 64'h0);

      // Single requester: grant one cycle after the request is seen.
      req = 4'b0001;
      step();
      check("t1_gv",   64'(o_grant_valid), 64'h1);
      check("t1_greq", 64'(o_grant_req),   64'h1);
      check("t1_gidx", 64'(o_grant_idx),   64'h0);
      req = '0;
      step();
      check("t1_lock", 64'(o_pool_lock),  64'h1);
      check("t1_free", 64'(o_free_count), 64'd31);

      // All four requesting: round robin 0,1,2,3 on alternate cycles.
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         step();
         if (c % 2 == 0) begin
            check("t2_greq", 64'(o_grant_req), 64'(1 << (c / 2)));
            check("t2_gidx", 64'(o_grant_idx), 64'(c / 2));
         end else begin
            check("t2_cool", 64'(o_grant_valid), 64'h0);
         end
      end
      check("t2_lock", 64'(o_pool_lock), 64'hF);

      // Fill the pool, then hold requests while full.
      for (int c = 8; c < 64; c++) step();
      check("t3_full", 64'(o_pool_full),  64'h1);
      check("t3_free", 64'(o_free_count), 64'd0);
      for (int c = 0; c < 4; c++) begin
         step();
         check("t3_nogrant", 64'(o_grant_valid), 64'h0);
      end
      rel_valid = 1; rel_idx = 5'd17;
      step();
      rel_valid = 0;
      check("t3_relfree", 64'(o_pool_full), 64'h0);
      step();
      check("t3_gidx",  64'(o_grant_idx), 64'd17);
      check("t3_gv",    64'(o_grant_valid), 64'h1);
      check("t3_full2", 64'(o_pool_full), 64'h1);

      // Release of an unlocked gate.
      do_reset();
      rel_valid = 1; rel_idx = 5'd5;
      step();
      rel_valid = 0;
      check("t4_err",  64'(o_rel_err),   64'h1);
      check("t4_lock", 64'(o_pool_lock), 64'h0);
      step();
      check("t4_err_once", 64'(o_rel_err), 64'h0);

      // Same-cycle grant and release on bitmap 0x7.
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 5; c++) step();
      req = '0;
      check("t5_pre", 64'(o_pool_lock), 64'h7);
      step();
      req = 4'b0001; rel_valid = 1; rel_idx = 5'd1;
      step();
      req = '0; rel_valid = 0;
      check("t5_gidx", 64'(o_grant_idx), 64'd3);
      check("t5_lock", 64'(o_pool_lock), 64'hD);

      // Reset in the cycle of a grant request with bitmap 0xFF.
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 16; c++) step();
      check("t6_pre", 64'(o_pool_lock), 64'hFF);
      rst = 1;
      step();
      rst = 0; req = '0;
      check("t6_gv",   64'(o_grant_valid), 64'h0);
      check("t6_lock", 64'(o_pool_lock),  64'h0);
      check("t6_free", 64'(o_free_count), 64'd32);

      // Randomized traffic with requesters that drop after being granted.
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int r = 0; r < NR; r++)
            if (!pend[r] && $urandom_range(0, 3) == 0) pend[r] = 1'b1;
         req       = pend;
         rel_valid = ($urandom_range(0, 2) == 0);
         rel_idx   = IW'($urandom_range(0, PW - 1));
         step();
         if (e_gv) pend = pend & ~e_greq;
         if (rst)  pend = '0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gate_pool_arbiter.md
Name: gate_pool_arbiter

Overview:
- Shares a pool of POOL_WIDTH gates between N_REQ requesters.
- Keeps the pool lock bitmap: 1 = gate in use, 0 = gate free.
- Grants the lowest-index free gate to requesters in round-robin order, and accepts gate releases.
- Is the owner that drives the pool lock vector consumed by the gate-index finder logic.

Parameters:
- POOL_WIDTH, 32, number of gates in the pool (power of two, 2..256).
- N_REQ, 4, number of requesters (1..16).
- IDX_W, 5, gate index width; must equal log2(POOL_WIDTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_req  input  N_REQ  level request per requester; held high until granted.
- i_rel_valid  input  1  release strobe, one cycle.
- i_rel_idx  input  IDX_W  index of the gate being released.
- o_grant_valid  output  1  one-cycle grant pulse.
- o_grant_req  output  N_REQ  one-hot id of the granted requester; valid with o_grant_valid, else 0.
- o_grant_idx  output  IDX_W  gate index granted; valid with o_grant_valid, else 0.
- o_pool_lock  output  POOL_WIDTH  registered lock bitmap.
- o_pool_full  output  1  all lock bits set (registered).
- o_free_count  output  IDX_W+1  number of clear lock bits (registered).
- o_rel_err  output  1  one-cycle pulse: release of a gate that is not locked.

Behaviour:
- Reset values:
  - o_pool_lock = 0, o_pool_full = 0, o_free_count = POOL_WIDTH.
  - o_grant_valid = 0, o_grant_req = 0, o_grant_idx = 0, o_rel_err = 0.
  - Round-robin pointer = 0; FSM = ARB.
- FSM has two states, ARB and COOL.
  - In ARB, a grant fires when i_req != 0 and o_pool_full == 0.
    - Requester selection: first set bit of i_req at or after the pointer, wrapping modulo N_REQ.
    - Gate selection: lowest-index 0 bit of o_pool_lock.
    - Next edge: o_grant_valid = 1, o_grant_req = one-hot of the winner, o_grant_idx = gate index, lock bit set.
    - The pointer advances to winner+1, wrapping from N_REQ-1 to 0. Next state is COOL.
  - In ARB with no grant, outputs are 0 and the state stays ARB.
  - COOL lasts exactly one cycle, with no grant; next state is ARB. This gives the winner time to drop i_req.
  - Maximum throughput is one grant per 2 cycles. Grant latency from a request seen in ARB is 1 cycle.
- Requester handshake: a requester deasserts i_req in the cycle after it sees its o_grant_req bit. A request still high in ARB after COOL is treated as a new request.
- Release:
  - When i_rel_valid = 1 and lock[i_rel_idx] = 1, the bit clears at the next edge.
  - When lock[i_rel_idx] = 0, the bitmap is unchanged and o_rel_err pulses at the next edge.
  - Releases are processed in either FSM state.
- Same-cycle grant and release:
  - Grant selection uses the registered bitmap before the release.
  - A gate freed this cycle is not eligible until the next ARB.
  - When a grant and a release hit different indices, both updates apply.
- Pool-full boundary:
  - With o_pool_full = 1 there is no grant; requests stay pending and the pointer does not move.
  - A release during full makes the gate eligible in the next ARB cycle.
- o_free_count and o_pool_full are derived from the updated bitmap and registered, so they are valid the same edge the lock bitmap changes.
- Reset mid-operation: rst overrides everything that cycle. A pending grant is dropped, the bitmap clears, and the FSM returns to ARB.
- All index arithmetic is unsigned, IDX_W bits wide. The pointer is ceil(log2(N_REQ)) bits wide, minimum 1.

Test Plan:
- Reset, then i_req = 4'b0001 held → o_grant_valid pulses at cycle 1 with o_grant_req = 0001 and o_grant_idx = 0. Afterwards o_pool_lock = 0x00000001 and o_free_count = 31.
- i_req = 4'b1111 held for 8 cycles → grants go to requesters 0, 1, 2, 3 on alternating cycles with gate indices 0, 1, 2, 3. o_pool_lock = 0x0000000F.
- Lock all 32 gates → o_pool_full = 1, o_free_count = 0, and held requests get no grant. Releasing index 17 → the next ARB grants gate 17 and o_pool_full is 1 again afterwards.
- Release index 5 while it is unlocked → o_rel_err pulses once and o_pool_lock is unchanged.
- Bitmap 0x00000007, a grant in ARB and release of index 1 in the same cycle → grant index 3 and bitmap 0x0000000D.
- rst asserted in the cycle of a grant request with bitmap 0x000000FF → no grant pulse, and o_pool_lock = 0 and o_free_count = 32 the next cycle.
